traffic_phase_monitor: RTL

Checker stage directly downstream of the traffic-light controller. It consumes the controller's 3-bit active-low LED code every clock and decodes the current phase. It tracks each phase's run length against the programmed schedule and flags sequence and duration violations. It also counts completed good cycles for status/debug logic.

---
 rtl/traffic_pkg.sv | 36 +++
 rtl/traffic_phase_monitor_if.sv | 35 +++
 rtl/traffic_phase_monitor_phase_decode.sv | 36 +++
 rtl/traffic_phase_monitor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared definitions for the traffic-light controller and its phase monitor.
//   LED_RED / LED_GRN / LED_BLU : active-low LED codes driven by the controller
//   LED_OFF                     : all LEDs dark, used as the "no code seen" value
//   phase_t                     : decoded phase (NONE, RED, GREEN, BLUE)
//   nextPhase()                 : the legal successor of a phase in the cycle
// ---------------------------------------------------------------------------
package traffic_pkg;

    localparam logic [2:0] LED_RED = 3'b101;
    localparam logic [2:0] LED_GRN = 3'b110;
    localparam logic [2:0] LED_BLU = 3'b011;
    localparam logic [2:0] LED_OFF = 3'b111;

    // Run lengths are held in 5 bits and stick at this value.
    localparam logic [4:0] RUN_MAX = 5'd31;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        RED   = 2'd1,
        GREEN = 2'd2,
        BLUE  = 2'd3
    } phase_t;

    // The controller cycles red -> green -> blue -> red; nothing follows NONE.
    function automatic phase_t nextPhase(input phase_t p);
        case (p)
            RED:     return GREEN;
            GREEN:   return BLUE;
            BLUE:    return RED;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_monitor_if.sv
// ---------------------------------------------------------------------------
// traffic_phase_monitor_if
// Bundles the LED code feeding the phase monitor with the monitor's status
// outputs.
//   led_in    : controller LED code (driven by master)
//   phase     : decoded current phase
//   locked    : monitor synchronised to the schedule
//   err_len   : one-cycle pulse, phase run length wrong
//   err_seq   : one-cycle pulse, illegal order or invalid code while locked
//   cycle_cnt : completed good red-green-blue periods (wrapping)
//   err_cnt   : saturating error-event count (0 when the counter is not built)
// Modports: master = code source / status consumer, slave = the monitor.
// ---------------------------------------------------------------------------
interface traffic_phase_monitor_if;
    import traffic_pkg::*;

    logic [2:0] led_in;
    phase_t     phase;
    logic       locked;
    logic       err_len;
    logic       err_seq;
    logic [7:0] cycle_cnt;
    logic [7:0] err_cnt;

    modport master (
        output led_in,
        input  phase, locked, err_len, err_seq, cycle_cnt, err_cnt
    );

    modport slave (
        input  led_in,
        output phase, locked, err_len, err_seq, cycle_cnt, err_cnt
    );

endinterface

// File: rtl/traffic_phase_monitor_phase_decode.sv
// ---------------------------------------------------------------------------
// phase_decode
// Purely combinational decode of an LED code into a phase, plus a check of
// whether that phase legally follows a given previous phase.
//   i_code      : LED code to decode
//   i_prevPhase : phase the code is being compared against
//   o_phase     : decoded phase (NONE for any unrecognised code)
//   o_valid     : code is one of the three legal LED codes
//   o_legalSucc : code is valid and is the successor of i_prevPhase
// ---------------------------------------------------------------------------
module phase_decode
    import traffic_pkg::*;
(
    input  logic [2:0] i_code,
    input  phase_t     i_prevPhase,
    output phase_t     o_phase,
    output logic       o_valid,
    output logic       o_legalSucc
);

    // Map the active-low LED pattern onto a phase; everything else is NONE.
    always_comb begin
        o_phase     = NONE;
        o_valid     = 1'b0;
        o_legalSucc = 1'b0;
        case (i_code)
            LED_RED: o_phase = RED;
            LED_GRN: o_phase = GREEN;
            LED_BLU: o_phase = BLUE;
            default: o_phase = NONE;
        endcase
        o_valid     = (o_phase != NONE);
        o_legalSucc = o_valid && (o_phase == nextPhase(i_prevPhase));
    end

endmodule

// File: rtl/traffic_phase_monitor.sv
// ---------------------------------------------------------------------------
// traffic_phase_monitor
// Sits behind the traffic-light controller, decodes its LED code every clock,
// checks each phase's run length against the programmed schedule and the
// order of phases, and counts completed good periods.
//   clk  : clock
//   rst  : asynchronous, active-low reset
//   mon  : traffic_phase_monitor_if.slave (led_in in, status outputs out)
// Parameters RED_LEN / GRN_LEN / BLU_LEN give the expected number of cycles
// each code is held (1..30).
// Build option: define PHASE_MON_ERRCNT_EN to include the saturating error
// event counter on err_cnt; otherwise err_cnt is tied to zero.
// ---------------------------------------------------------------------------
module traffic_phase_monitor
    import traffic_pkg::*;
#(
    parameter int RED_LEN = 10,
    parameter int GRN_LEN = 5,
    parameter int BLU_LEN = 3
)(
    input  logic                 clk,
    input  logic                 rst,
    traffic_phase_monitor_if.slave mon
);

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_RED      = 2'd1,
        S_GREEN    = 2'd2,
        S_BLUE     = 2'd3
    } monState_t;

    monState_t  r_state;
    monState_t  w_nextState;
    logic [2:0] r_curCode;
    logic [4:0] r_runLen;
    phase_t     r_phase;
    logic       r_locked;
    logic       r_errLen;
    logic       r_errSeq;
    logic [7:0] r_cycleCnt;

    phase_t     w_curPhase;
    phase_t     w_inPhase;
    logic       w_inValid;
    logic       w_legalSucc;
    logic       w_sameCode;
    logic       w_isLocked;
    logic [4:0] w_expLen;
    logic       w_errLen;
    logic       w_errSeq;
    logic       w_cycleInc;

    function automatic phase_t stateToPhase(input monState_t s);
        case (s)
            S_RED:   return RED;
            S_GREEN: return GREEN;
            S_BLUE:  return BLUE;
            default: return NONE;
        endcase
    endfunction

    function automatic monState_t phaseToState(input phase_t p);
        case (p)
            RED:     return S_RED;
            GREEN:   return S_GREEN;
            BLUE:    return S_BLUE;
            default: return S_UNLOCKED;
        endcase
    endfunction

    // While locked the FSM state names the phase being timed, so the
    // successor check is made against the state rather than the stored code.
    assign w_curPhase = stateToPhase(r_state);
    assign w_isLocked = (r_state != S_UNLOCKED);
    assign w_sameCode = (mon.led_in == r_curCode);

    phase_decode u_decode (
        .i_code      (mon.led_in),
        .i_prevPhase (w_curPhase),
        .o_phase     (w_inPhase),
        .o_valid     (w_inValid),
        .o_legalSucc (w_legalSucc)
    );

    // Expected hold length for whichever phase is currently being timed.
    always_comb begin
        w_expLen = 5'd0;
        case (r_state)
            S_RED:   w_expLen = 5'(RED_LEN);
            S_GREEN: w_expLen = 5'(GRN_LEN);
            S_BLUE:  w_expLen = 5'(BLU_LEN);
            default: w_expLen = 5'd0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_UNLOCKED;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and error decisions. An overrun is caught on the sample that
    // would exceed the expected length, so the following change-out edge is
    // already unlocked and cannot report the same run a second time. On a
    // code change, length and order are judged independently and may both
    // fire; only a clean blue-to-red hand-over completes a period.
    always_comb begin
        w_nextState = r_state;
        w_errLen    = 1'b0;
        w_errSeq    = 1'b0;
        w_cycleInc  = 1'b0;
        if (w_sameCode) begin
            if (w_isLocked && (r_runLen == w_expLen)) begin
                w_errLen    = 1'b1;
                w_nextState = S_UNLOCKED;
            end
        end else if (w_isLocked) begin
            w_errLen = (r_runLen != w_expLen);
            w_errSeq = !w_inValid || !w_legalSucc;
            if (w_errLen || w_errSeq) begin
                w_nextState = S_UNLOCKED;
            end else begin
                w_nextState = phaseToState(w_inPhase);
                w_cycleInc  = (r_state == S_BLUE);
            end
        end else if (w_inPhase == RED) begin
            w_nextState = S_RED;
        end
    end

    // Run tracking and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_curCode  <= LED_OFF;
            r_runLen   <= 5'd0;
            r_phase    <= NONE;
            r_locked   <= 1'b0;
            r_errLen   <= 1'b0;
            r_errSeq   <= 1'b0;
            r_cycleCnt <= 8'd0;
        end else begin
            if (w_sameCode) begin
                if (r_runLen != RUN_MAX) begin
                    r_runLen <= r_runLen + 5'd1;
                end
            end else begin
                r_curCode <= mon.led_in;
                r_runLen  <= 5'd1;
            end
            r_phase    <= w_inPhase;
            r_locked   <= (w_nextState != S_UNLOCKED);
            r_errLen   <= w_errLen;
            r_errSeq   <= w_errSeq;
            r_cycleCnt <= r_cycleCnt + {7'd0, w_cycleInc};
        end
    end

    assign mon.phase     = r_phase;
    assign mon.locked    = r_locked;
    assign mon.err_len   = r_errLen;
    assign mon.err_seq   = r_errSeq;
    assign mon.cycle_cnt = r_cycleCnt;

`ifdef PHASE_MON_ERRCNT_EN
    logic [7:0] r_errCnt;

    // One increment per erroneous edge, even when both errors fire together;
    // it updates on the same edge as the error pulse and sticks at 255.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_errCnt <= 8'd0;
        end else if ((w_errLen || w_errSeq) && (r_errCnt != 8'hFF)) begin
            r_errCnt <= r_errCnt + 8'd1;
        end
    end

    assign mon.err_cnt = r_errCnt;
`else
    assign mon.err_cnt = 8'd0;
`endif

endmodule
